// File: rtl/demorgan_pkg.sv
// Shared types and helpers for the De Morgan gate self-test sequencer.
package demorgan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_APPLY = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int NUM_VECTORS = 4;

   // Golden outputs for vec = {a,b}, ordered nA,nB,nAandnB,nAornB,AnorB,AnandB (MSB first).
   function automatic logic [5:0] expected_outputs(input logic [1:0] vec);
      logic a;
      logic b;
      a = vec[1];
      b = vec[0];
      return {~a, ~b, ~a & ~b, ~a | ~b, ~(a | b), ~(a & b)};
   endfunction

endpackage

// File: rtl/demorgan_sweep_ctrl_if.sv
// Host-side run handshake of the De Morgan self-test sequencer.
interface demorgan_sweep_ctrl_if #(
   parameter int ERR_W = 8
);
   logic             start;
   logic             abort;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;

   modport master (
      output start, abort,
      input  busy, done, pass, err_count
   );

   modport slave (
      input  start, abort,
      output busy, done, pass, err_count
   );
endinterface

// File: rtl/demorgan_settle_timer.sv
// Loadable down-counter that times the APPLY dwell; zero flags expiry.
module demorgan_settle_timer #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);
   logic [WIDTH-1:0] count;

   // Reload while idle-side, count down to zero while enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);
endmodule

// File: rtl/demorgan_sweep_ctrl.sv
// Built-in self-test sequencer for one two-input De Morgan gate block.
// Sweeps A/B through all four vectors, compares the six block outputs,
// and reports a saturating mismatch count and pass/fail to the host.
// Optional first-failure capture: define DEMORGAN_FIRST_FAIL_LOG_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | waiting for start, A/B driven low
// ST_LOAD  | clear run results and vector/pass indices
// ST_APPLY | drive current vector, wait SETTLE_CYCLES+1 cycles
// ST_CHECK | compare block outputs, advance vector or pass
// ST_DONE  | pulse done, publish pass, return to idle
module demorgan_sweep_ctrl
   import demorgan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int NUM_PASSES    = 1,
   parameter int ERR_W         = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   demorgan_sweep_ctrl_if.slave  host,
   output logic                  dut_A,
   output logic                  dut_B,
   input  logic                  dut_nA,
   input  logic                  dut_nB,
   input  logic                  dut_nAandnB,
   input  logic                  dut_nAornB,
   input  logic                  dut_AnorB,
   input  logic                  dut_AnandB
`ifdef DEMORGAN_FIRST_FAIL_LOG_EN
   ,
   output logic [1:0]            first_fail_vec,
   output logic [5:0]            first_fail_mask,
   output logic                  first_fail_valid
`endif
);
   localparam int TW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam int PW = (NUM_PASSES < 2) ? 1 : $clog2(NUM_PASSES);
   localparam logic [1:0]    LAST_VEC  = 2'(NUM_VECTORS - 1);
   localparam logic [PW-1:0] LAST_PASS = PW'(NUM_PASSES - 1);

   state_t           state;
   logic [1:0]       vec;
   logic [PW-1:0]    pass_idx;
   logic             busy_r;
   logic             done_r;
   logic             pass_r;
   logic [ERR_W-1:0] err_r;
   logic             settle_zero;
   logic [5:0]       observed;
   logic [5:0]       mism;

`ifdef DEMORGAN_FIRST_FAIL_LOG_EN
   logic [1:0]       ff_vec;
   logic [5:0]       ff_mask;
   logic             ff_valid;
`endif

   assign observed = {dut_nA, dut_nB, dut_nAandnB, dut_nAornB, dut_AnorB, dut_AnandB};
   assign mism     = observed ^ expected_outputs(vec);

   // Timer is preloaded in every non-APPLY state so APPLY always starts with a full dwell.
   demorgan_settle_timer #(.WIDTH(TW)) u_settle (
      .clk      (clk),
      .reset    (reset),
      .load     (state != ST_APPLY),
      .en       (state == ST_APPLY),
      .load_val (TW'(SETTLE_CYCLES)),
      .zero     (settle_zero)
   );

   // Sequencer: state, vector/pass indices, A/B drive and run results.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         vec      <= '0;
         pass_idx <= '0;
         dut_A    <= 1'b0;
         dut_B    <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         pass_r   <= 1'b0;
         err_r    <= '0;
`ifdef DEMORGAN_FIRST_FAIL_LOG_EN
         ff_vec   <= '0;
         ff_mask  <= '0;
         ff_valid <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         if ((state == ST_LOAD || state == ST_APPLY || state == ST_CHECK) && host.abort) begin
            // Abort drops the run; partial err_count stays visible, mismatch this cycle is not counted.
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            pass_r <= 1'b0;
            dut_A  <= 1'b0;
            dut_B  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  dut_A <= 1'b0;
                  dut_B <= 1'b0;
                  if (host.start) state <= ST_LOAD;
               end
               ST_LOAD: begin
                  err_r    <= '0;
                  pass_r   <= 1'b0;
                  vec      <= '0;
                  pass_idx <= '0;
                  busy_r   <= 1'b1;
                  dut_A    <= 1'b0;
                  dut_B    <= 1'b0;
`ifdef DEMORGAN_FIRST_FAIL_LOG_EN
                  ff_vec   <= '0;
                  ff_mask  <= '0;
                  ff_valid <= 1'b0;
`endif
                  state    <= ST_APPLY;
               end
               ST_APPLY: begin
                  {dut_A, dut_B} <= vec;
                  if (settle_zero) state <= ST_CHECK;
               end
               ST_CHECK: begin
                  if (mism != '0) begin
                     if (err_r != {ERR_W{1'b1}}) err_r <= err_r + 1'b1;
`ifdef DEMORGAN_FIRST_FAIL_LOG_EN
                     if (!ff_valid) begin
                        ff_vec   <= vec;
                        ff_mask  <= mism;
                        ff_valid <= 1'b1;
                     end
`endif
                  end
                  if (vec != LAST_VEC) begin
                     vec            <= vec + 1'b1;
                     {dut_A, dut_B} <= vec + 1'b1;
                     state          <= ST_APPLY;
                  end else if (pass_idx < LAST_PASS) begin
                     pass_idx       <= pass_idx + 1'b1;
                     vec            <= '0;
                     {dut_A, dut_B} <= 2'b00;
                     state          <= ST_APPLY;
                  end else begin
                     state <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  pass_r <= (err_r == '0);
                  dut_A  <= 1'b0;
                  dut_B  <= 1'b0;
                  state  <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign host.busy      = busy_r;
   assign host.done      = done_r;
   assign host.pass      = pass_r;
   assign host.err_count = err_r;

`ifdef DEMORGAN_FIRST_FAIL_LOG_EN
   assign first_fail_vec   = ff_vec;
   assign first_fail_mask  = ff_mask;
   assign first_fail_valid = ff_valid;
`endif
endmodule
